// File: rtl/cond_pkg.sv
// Shared definitions for the condition unit: condition-field encodings
// and bit positions inside the NZCV flag register and the FlagW field.
package cond_pkg;

    typedef enum logic [3:0] {
        EQ = 4'b0000,
        NE = 4'b0001,
        CS = 4'b0010,
        CC = 4'b0011,
        MI = 4'b0100,
        PL = 4'b0101,
        VS = 4'b0110,
        VC = 4'b0111,
        HI = 4'b1000,
        LS = 4'b1001,
        GE = 4'b1010,
        LT = 4'b1011,
        GT = 4'b1100,
        LE = 4'b1101,
        AL = 4'b1110,
        NV = 4'b1111
    } cond_t;

    localparam int unsigned FLAG_N = 3;
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_V = 0;

    localparam int unsigned FW_NZ = 1;
    localparam int unsigned FW_CV = 0;

endpackage

// File: rtl/cond_check.sv
// Combinational evaluation of a 4-bit ARM condition field against NZCV flags.
module cond_check
    import cond_pkg::*;
(
    input  logic [3:0] Cond,
    input  logic [3:0] Flags,
    output logic       CondEx
);

    logic n, z, c, v;

    always_comb begin
        n = Flags[FLAG_N];
        z = Flags[FLAG_Z];
        c = Flags[FLAG_C];
        v = Flags[FLAG_V];
        CondEx = 1'b1;
        unique case (cond_t'(Cond))
            EQ: CondEx = z;
            NE: CondEx = ~z;
            CS: CondEx = c;
            CC: CondEx = ~c;
            MI: CondEx = n;
            PL: CondEx = ~n;
            VS: CondEx = v;
            VC: CondEx = ~v;
            HI: CondEx = c & ~z;
            LS: CondEx = ~c | z;
            GE: CondEx = (n == v);
            LT: CondEx = (n != v);
            GT: CondEx = ~z & (n == v);
            LE: CondEx = z | (n != v);
            // NV is executed unconditionally in this subset
            AL, NV: CondEx = 1'b1;
            default: CondEx = 1'b1;
        endcase
    end

endmodule

// File: rtl/cond_logic.sv
// Condition unit: NZCV flag register, condition gating of PC/reg/mem writes,
// and executed/squashed instruction counters for on-board debug.
module cond_logic
    import cond_pkg::*;
#(
    parameter int unsigned CW = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en,
    input  logic          flush,
    input  logic          Valid,
    input  logic [3:0]    Cond,
    input  logic [3:0]    ALUFlags,
    input  logic [1:0]    FlagW,
    input  logic          ShiftOp,
    input  logic          ShCarry,
    input  logic          PCS,
    input  logic          RegW,
    input  logic          MemW,
    input  logic          NoWrite,
    output logic          CondEx,
    output logic          PCSrc,
    output logic          RegWrite,
    output logic          MemWrite,
    output logic [3:0]    Flags,
    output logic [CW-1:0] ExecCount,
    output logic [CW-1:0] SquashCount
);

    logic [3:0]    flags_q, flags_d;
    logic [CW-1:0] exec_q, exec_d;
    logic [CW-1:0] squash_q, squash_d;
    logic          cond_ex;
    logic          go;

    // Condition is judged on the stored flags only; no ALUFlags forwarding.
    cond_check u_cond_check (
        .Cond   (Cond),
        .Flags  (flags_q),
        .CondEx (cond_ex)
    );

    always_comb begin
        go       = Valid & cond_ex & ~flush & ~reset;
        CondEx   = cond_ex;
        PCSrc    = PCS & go;
        MemWrite = MemW & go;
        RegWrite = RegW & ~NoWrite & go;

        flags_d = flags_q;
        if (go) begin
            if (FlagW[FW_NZ]) begin
                flags_d[FLAG_N] = ALUFlags[FLAG_N];
                flags_d[FLAG_Z] = ALUFlags[FLAG_Z];
            end
            if (FlagW[FW_CV]) begin
                if (ShiftOp) begin
                    flags_d[FLAG_C] = ShCarry;
                end else begin
                    flags_d[FLAG_C] = ALUFlags[FLAG_C];
                    flags_d[FLAG_V] = ALUFlags[FLAG_V];
                end
            end
        end

        exec_d   = exec_q;
        squash_d = squash_q;
        if (Valid && !flush) begin
            if (cond_ex) begin
                exec_d = exec_q + CW'(1);
            end else begin
                squash_d = squash_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            flags_q  <= '0;
            exec_q   <= '0;
            squash_q <= '0;
        end else if (en) begin
            flags_q  <= flags_d;
            exec_q   <= exec_d;
            squash_q <= squash_d;
        end
    end

    assign Flags       = flags_q;
    assign ExecCount   = exec_q;
    assign SquashCount = squash_q;

endmodule

// File: tb/tb_cond_logic.sv
// Self-checking bench for cond_logic: directed vector table, a 16x16
// condition/flag sweep, and a queue of expected post-edge state.
module tb_cond_logic;

    localparam int unsigned CW_T = 4;

    logic            clk;
    logic            reset, en, flush, Valid;
    logic [3:0]      Cond, ALUFlags;
    logic [1:0]      FlagW;
    logic            ShiftOp, ShCarry, PCS, RegW, MemW, NoWrite;
    logic            CondEx, PCSrc, RegWrite, MemWrite;
    logic [3:0]      Flags;
    logic [CW_T-1:0] ExecCount, SquashCount;

    cond_logic #(.CW(CW_T)) dut (
        .clk         (clk),
        .reset       (reset),
        .en          (en),
        .flush       (flush),
        .Valid       (Valid),
        .Cond        (Cond),
        .ALUFlags    (ALUFlags),
        .FlagW       (FlagW),
        .ShiftOp     (ShiftOp),
        .ShCarry     (ShCarry),
        .PCS         (PCS),
        .RegW        (RegW),
        .MemW        (MemW),
        .NoWrite     (NoWrite),
        .CondEx      (CondEx),
        .PCSrc       (PCSrc),
        .RegWrite    (RegWrite),
        .MemWrite    (MemWrite),
        .Flags       (Flags),
        .ExecCount   (ExecCount),
        .SquashCount (SquashCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst, en, fl, vld;
        logic [3:0] cond;
        logic [1:0] fw;
        logic [3:0] alu;
        logic       sop, shc, pcs, rw, mw, nw;
        logic [3:0] gates;      // {CondEx, PCSrc, RegWrite, MemWrite}
        logic [3:0] flags_next;
    } vec_t;

    typedef struct {
        string      name;
        logic [3:0] flags;
        int         exec;
        int         sq;
    } sb_t;

    vec_t tbl[24];
    sb_t  sbq[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   exp_exec = 0;
    int   exp_sq   = 0;

    function automatic vec_t mk(input logic rst, en_v, fl, vld,
                                input logic [3:0] cond, input logic [1:0] fw,
                                input logic [3:0] alu, input logic sop, shc,
                                input logic pcs, rw, mw, nw,
                                input logic [3:0] gates, flags_next);
        vec_t v;
        v.rst = rst; v.en = en_v; v.fl = fl; v.vld = vld;
        v.cond = cond; v.fw = fw; v.alu = alu; v.sop = sop; v.shc = shc;
        v.pcs = pcs; v.rw = rw; v.mw = mw; v.nw = nw;
        v.gates = gates; v.flags_next = flags_next;
        return v;
    endfunction

    function automatic logic ref_cond(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v;
        {n, z, cy, v} = f;
        case (c)
            4'd0:  return z;
            4'd1:  return !z;
            4'd2:  return cy;
            4'd3:  return !cy;
            4'd4:  return n;
            4'd5:  return !n;
            4'd6:  return v;
            4'd7:  return !v;
            4'd8:  return cy && !z;
            4'd9:  return !cy || z;
            4'd10: return n == v;
            4'd11: return n != v;
            4'd12: return !z && (n == v);
            4'd13: return z || (n != v);
            default: return 1'b1;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input string name, input vec_t v);
        sb_t e;
        reset = v.rst; en = v.en; flush = v.fl; Valid = v.vld;
        Cond = v.cond; FlagW = v.fw; ALUFlags = v.alu;
        ShiftOp = v.sop; ShCarry = v.shc;
        PCS = v.pcs; RegW = v.rw; MemW = v.mw; NoWrite = v.nw;

        if (v.rst) begin
            exp_exec = 0;
            exp_sq   = 0;
        end else if (v.en && v.vld && !v.fl) begin
            if (v.gates[3]) exp_exec++;
            else            exp_sq++;
        end
        e.name  = name;
        e.flags = v.flags_next;
        e.exec  = exp_exec % (1 << CW_T);
        e.sq    = exp_sq % (1 << CW_T);
        sbq.push_back(e);

        @(negedge clk);
        chk({name, ".gates"}, 32'({CondEx, PCSrc, RegWrite, MemWrite}), 32'(v.gates));

        @(posedge clk);
        #1;
        e = sbq.pop_front();
        chk({e.name, ".flags"}, 32'(Flags), 32'(e.flags));
        chk({e.name, ".exec"}, 32'(ExecCount), 32'(e.exec));
        chk({e.name, ".squash"}, 32'(SquashCount), 32'(e.sq));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0] f4, c4, g;
        vec_t v;

        //           rst en fl vld cond   fw     alu    sop shc pcs rw mw nw  gates    flags
        tbl[0]  = mk(1, 1, 0, 1, 4'hE, 2'b11, 4'hF, 0, 0, 1, 1, 1, 0, 4'b1000, 4'h0);
        tbl[1]  = mk(0, 1, 0, 1, 4'hE, 2'b11, 4'h6, 0, 0, 0, 0, 0, 0, 4'b1000, 4'h6);
        tbl[2]  = mk(0, 1, 0, 1, 4'h0, 2'b00, 4'h0, 0, 0, 0, 1, 0, 0, 4'b1010, 4'h6);
        tbl[3]  = mk(0, 1, 0, 1, 4'hE, 2'b11, 4'hF, 0, 0, 0, 0, 0, 0, 4'b1000, 4'hF);
        tbl[4]  = mk(0, 1, 0, 1, 4'hE, 2'b10, 4'h0, 0, 0, 0, 0, 0, 0, 4'b1000, 4'h3);
        tbl[5]  = mk(0, 1, 0, 1, 4'hE, 2'b01, 4'h0, 1, 0, 0, 0, 0, 0, 4'b1000, 4'h1);
        tbl[6]  = mk(0, 1, 0, 1, 4'hE, 2'b01, 4'h2, 0, 0, 0, 0, 0, 0, 4'b1000, 4'h2);
        tbl[7]  = mk(0, 1, 0, 1, 4'hE, 2'b11, 4'h0, 0, 0, 0, 0, 0, 0, 4'b1000, 4'h0);
        tbl[8]  = mk(0, 1, 0, 1, 4'h1, 2'b00, 4'h0, 0, 0, 0, 0, 1, 0, 4'b1001, 4'h0);
        tbl[9]  = mk(0, 1, 0, 1, 4'h0, 2'b11, 4'hF, 0, 0, 0, 0, 1, 0, 4'b0000, 4'h0);
        tbl[10] = mk(0, 1, 0, 1, 4'hE, 2'b00, 4'h0, 0, 0, 0, 1, 0, 1, 4'b1000, 4'h0);
        tbl[11] = mk(0, 1, 0, 1, 4'hE, 2'b11, 4'h8, 0, 0, 0, 0, 0, 0, 4'b1000, 4'h8);
        tbl[12] = mk(0, 1, 0, 1, 4'hA, 2'b00, 4'h0, 0, 0, 1, 0, 0, 0, 4'b0000, 4'h8);
        tbl[13] = mk(0, 1, 0, 1, 4'hB, 2'b00, 4'h0, 0, 0, 1, 0, 0, 0, 4'b1100, 4'h8);
        tbl[14] = mk(0, 1, 0, 1, 4'hC, 2'b00, 4'h0, 0, 0, 0, 0, 0, 0, 4'b0000, 4'h8);
        tbl[15] = mk(0, 1, 0, 1, 4'hD, 2'b00, 4'h0, 0, 0, 0, 0, 0, 0, 4'b1000, 4'h8);
        tbl[16] = mk(0, 1, 0, 1, 4'hE, 2'b11, 4'h9, 0, 0, 0, 0, 0, 0, 4'b1000, 4'h9);
        tbl[17] = mk(0, 1, 0, 1, 4'hA, 2'b00, 4'h0, 0, 0, 1, 0, 0, 0, 4'b1100, 4'h9);
        tbl[18] = mk(0, 1, 0, 1, 4'hC, 2'b00, 4'h0, 0, 0, 0, 1, 0, 0, 4'b1010, 4'h9);
        tbl[19] = mk(0, 0, 0, 1, 4'hE, 2'b11, 4'h6, 0, 0, 1, 0, 0, 0, 4'b1100, 4'h9);
        tbl[20] = mk(0, 1, 1, 1, 4'hE, 2'b11, 4'h0, 0, 0, 1, 0, 0, 0, 4'b1000, 4'h9);
        tbl[21] = mk(0, 1, 0, 0, 4'hE, 2'b11, 4'h0, 0, 0, 1, 0, 1, 0, 4'b1000, 4'h9);
        tbl[22] = mk(0, 1, 0, 1, 4'hE, 2'b00, 4'h0, 0, 0, 1, 0, 0, 0, 4'b1100, 4'h9);
        tbl[23] = mk(1, 0, 1, 1, 4'hE, 2'b11, 4'hF, 0, 0, 1, 0, 0, 0, 4'b1000, 4'h0);

        reset = 1'b1; en = 1'b0; flush = 1'b0; Valid = 1'b0;
        Cond = 4'hE; FlagW = 2'b00; ALUFlags = 4'h0;
        ShiftOp = 1'b0; ShCarry = 1'b0;
        PCS = 1'b0; RegW = 1'b0; MemW = 1'b0; NoWrite = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 24; i++) begin
            step($sformatf("vec%0d", i), tbl[i]);
        end

        for (int fi = 0; fi < 16; fi++) begin
            f4 = 4'(fi);
            step($sformatf("load%0h", f4),
                 mk(0, 1, 0, 1, 4'hE, 2'b11, f4, 0, 0, 0, 0, 0, 0, 4'b1000, f4));
            for (int ci = 0; ci < 16; ci++) begin
                c4 = 4'(ci);
                g[3] = ref_cond(c4, f4);
                g[2] = g[3];
                g[1] = g[3] & ~c4[0];
                g[0] = g[3];
                v = mk(0, 1, 0, 1, c4, 2'b00, 4'h0, 0, 0, 1, 1, 1, c4[0], g, f4);
                step($sformatf("sweep_f%0h_c%0h", f4, c4), v);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cond_logic.md
Name: cond_logic

Overview:
Condition unit directly downstream of the ALU in the ARM-subset datapath. It holds the architectural NZCV flag register and updates it from ALUFlags and the shifter carry. It evaluates the instruction's 4-bit condition field against the stored flags and gates the PC-source, register-write and memory-write requests. It also keeps executed/squashed instruction counters for FPGA debug.

Parameters:
CW, 16, width of the executed and squashed instruction counters

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
en  input  1  stage enable; 0 = stall, all state frozen
flush  input  1  squash the current instruction; no writes, no flag update
Valid  input  1  an instruction is present this cycle
Cond  input  4  instruction condition field, Instr[31:28]
ALUFlags  input  4  {N,Z,C,V} from the ALU, same cycle
FlagW  input  2  [1] update N,Z; [0] update C,V
ShiftOp  input  1  instruction is MOV/LSL/LSR/ASR/ROR (ALUControl 3'b100)
ShCarry  input  1  carry-out of the shifter
PCS  input  1  instruction writes the PC
RegW  input  1  instruction writes the register file
MemW  input  1  instruction writes memory
NoWrite  input  1  CMP/CMN/TST: suppress register write
CondEx  output  1  condition passed on the current stored flags
PCSrc  output  1  gated PCS
RegWrite  output  1  gated RegW
MemWrite  output  1  gated MemW
Flags  output  4  current flag register {N,Z,C,V}
ExecCount  output  CW  instructions executed
SquashCount  output  CW  instructions failing the condition

Behaviour:
- Reset, on a clock edge with reset=1: Flags=4'b0000, ExecCount=0, SquashCount=0. Reset wins over en, flush and Valid in the same cycle.
- While reset=1: PCSrc, RegWrite and MemWrite are held at 0.
- CondEx is combinational from the registered Flags, never from ALUFlags. Zero-cycle latency.
- Condition codes:
  - EQ=0000: Z
  - NE=0001: !Z
  - CS=0010: C
  - CC=0011: !C
  - MI=0100: N
  - PL=0101: !N
  - VS=0110: V
  - VC=0111: !V
  - HI=1000: C&!Z
  - LS=1001: !C|Z
  - GE=1010: N==V
  - LT=1011: N!=V
  - GT=1100: !Z&(N==V)
  - LE=1101: Z|(N!=V)
  - AL=1110: 1
  - 1111: treated as AL (1)
- Define go = Valid & CondEx & ~flush & ~reset.
- Write gating, combinational and independent of en:
  - PCSrc = PCS & go
  - MemWrite = MemW & go
  - RegWrite = RegW & ~NoWrite & go
- Flag update, on a clock edge where en & go:
  - If FlagW[1]: N,Z <= ALUFlags[3:2].
  - If FlagW[0] and ShiftOp=0: C,V <= ALUFlags[1:0].
  - If FlagW[0] and ShiftOp=1: C <= ShCarry; V is unchanged.
  - Bits not enabled hold their value.
  - New flags become visible to CondEx in the next cycle. There is no same-cycle forwarding.
- Counters, on a clock edge where en & Valid & ~flush & ~reset:
  - CondEx=1: ExecCount+1.
  - CondEx=0: SquashCount+1.
  - Both counters wrap modulo 2^CW.
- en=0: flags and counters hold. Gated outputs still follow their inputs; the downstream stall logic masks them.
- flush=1: no flag update, no counter change, all gated outputs 0, whatever the condition result.
- Valid=0: same effect as flush, except that flush is what the hazard unit uses to kill an instruction.

Decomposition:
- Package cond_pkg holds:
  - cond_t enum for the 16 codes (EQ..AL, NV=1111)
  - flag index constants FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0
  - FlagW bit constants FW_NZ=1, FW_CV=0
- Sub-module cond_check: purely combinational, inputs (Cond, Flags), output CondEx. It is reused later by the pipelined version.

Test Plan:
- Reset: reset=1 with Valid=1, PCS=RegW=MemW=1 -> PCSrc=RegWrite=MemWrite=0; after the edge Flags=0000 and both counters 0.
- Flag write then EQ: cycle 1 Cond=AL, FlagW=11, ALUFlags=0110, Valid=1 -> Flags=0110 next cycle. Cycle 2 Cond=EQ, RegW=1 -> CondEx=1, RegWrite=1, ExecCount=2.
- Partial update: Flags=1111; FlagW=10, ALUFlags=0000 -> Flags=0011. Then FlagW=01, ShiftOp=1, ShCarry=0 -> Flags=0001 (V kept).
- Squash: Flags=0000, Cond=NE then Cond=EQ with MemW=1 -> first MemWrite=0... correction: NE passes (MemWrite=1, ExecCount+1); EQ fails (MemWrite=0, SquashCount+1). A FlagW=11 on the failing instruction leaves Flags unchanged.
- Signed conditions: Flags N=1,V=0 -> GE=0, LT=1, GT=0, LE=1. Flags N=1,V=1,Z=0 -> GE=1, GT=1. Sweep all 16 codes over all 16 flag values against a reference model.
- Stall, flush and wrap:
  - en=0 with FlagW=11 -> Flags and counters frozen.
  - flush=1 with Cond=AL, PCS=1 -> PCSrc=0, no count.
  - CW=4: 16 executed instructions -> ExecCount wraps to 0.
